// File: rtl/sonic_tx_arbiter.sv
// sonic_tx_arbiter: round-robin arbiter for the shared PCIe backend transmit
// interface. Grants one of NUM_REQ clients at a time, keeps the grant across
// back-to-back TLPs of the same client, and inserts a one-cycle RELEASE gap
// before re-arbitrating from the client after the last owner.
// Optional feature: define SONIC_TX_ARB_WATCHDOG_EN to revoke a grant that sits
// in GRANT for WATCHDOG_CYCLES cycles without the client going busy.
module sonic_tx_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ID_WIDTH        = 2,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                init,
    input  logic [NUM_REQ-1:0]  req_ready,
    input  logic [NUM_REQ-1:0]  req_busy,
    input  logic                tx_ws,
    output logic [NUM_REQ-1:0]  tx_sel,
    output logic [NUM_REQ-1:0]  tx_ready_others,
    output logic [ID_WIDTH-1:0] grant_id,
    output logic                grant_valid,
    output logic [15:0]         grant_count,
    output logic                wd_error
);

    typedef enum logic [1:0] {IDLE, GRANT, BUSY, RELEASE} state_t;

    state_t              state_reg, state_next;
    logic [NUM_REQ-1:0]  tx_sel_reg, tx_sel_next;
    logic [ID_WIDTH-1:0] grant_id_reg, grant_id_next;
    logic [ID_WIDTH-1:0] rr_ptr_reg, rr_ptr_next;
    logic [15:0]         grant_count_reg, grant_count_next;
    logic                pick_found;
    logic [ID_WIDTH-1:0] pick_id;
    logic                cur_ready, cur_busy;
    logic                wd_timeout;

    // Ready/busy of the client currently holding (or last holding) the grant.
    assign cur_ready = req_ready[grant_id_reg];
    assign cur_busy  = req_busy[grant_id_reg];

    // First ready client at or after rr_ptr, wrapping; the lowest offset wins.
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_ready[idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_WIDTH'(idx);
            end
        end
    end

`ifdef SONIC_TX_ARB_WATCHDOG_EN
    logic [31:0] wd_cnt_reg;
    logic        wd_error_reg;

    // Fires on the cycle that would otherwise be the WATCHDOG_CYCLES-th idle GRANT cycle.
    assign wd_timeout = (state_reg == GRANT) && cur_ready && !cur_busy &&
                        (wd_cnt_reg == 32'(WATCHDOG_CYCLES - 1));

    // Idle-grant counter, cleared on every entry to GRANT; sticky error flag.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            wd_cnt_reg   <= '0;
            wd_error_reg <= 1'b0;
        end else if (init) begin
            wd_cnt_reg   <= '0;
            wd_error_reg <= 1'b0;
        end else begin
            if (state_next == GRANT && state_reg != GRANT)
                wd_cnt_reg <= '0;
            else if (state_reg == GRANT)
                wd_cnt_reg <= wd_cnt_reg + 32'd1;
            if (wd_timeout)
                wd_error_reg <= 1'b1;
        end
    end

    assign wd_error = wd_error_reg;
`else
    assign wd_timeout = 1'b0;
    assign wd_error   = 1'b0;
`endif

    // Next-state and next-output logic of the grant FSM.
    always_comb begin
        state_next       = state_reg;
        tx_sel_next      = tx_sel_reg;
        grant_id_next    = grant_id_reg;
        rr_ptr_next      = rr_ptr_reg;
        grant_count_next = grant_count_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found && !tx_ws) begin
                    state_next       = GRANT;
                    tx_sel_next      = NUM_REQ'(1) << pick_id;
                    grant_id_next    = pick_id;
                    grant_count_next = grant_count_reg + 16'd1;
                end
            end
            GRANT: begin
                if (cur_busy) begin
                    state_next = BUSY;
                end else if (!cur_ready || wd_timeout) begin
                    state_next  = RELEASE;
                    tx_sel_next = '0;
                end
            end
            BUSY: begin
                if (!cur_busy) begin
                    if (cur_ready) begin
                        state_next = GRANT;
                    end else begin
                        state_next  = RELEASE;
                        tx_sel_next = '0;
                    end
                end
            end
            RELEASE: begin
                state_next = IDLE;
                if (grant_id_reg == ID_WIDTH'(NUM_REQ - 1))
                    rr_ptr_next = '0;
                else
                    rr_ptr_next = grant_id_reg + 1'b1;
            end
            default: begin
                state_next  = IDLE;
                tx_sel_next = '0;
            end
        endcase
    end

    // State and output registers; init is a synchronous clear above all transitions.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            tx_sel_reg      <= '0;
            grant_id_reg    <= '0;
            rr_ptr_reg      <= '0;
            grant_count_reg <= '0;
        end else if (init) begin
            state_reg       <= IDLE;
            tx_sel_reg      <= '0;
            grant_id_reg    <= '0;
            rr_ptr_reg      <= '0;
            grant_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            tx_sel_reg      <= tx_sel_next;
            grant_id_reg    <= grant_id_next;
            rr_ptr_reg      <= rr_ptr_next;
            grant_count_reg <= grant_count_next;
        end
    end

    // A client may start only while it holds the grant and nobody else is busy.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_others
            assign tx_ready_others[gi] = ~tx_sel_reg[gi] |
                                         (|(req_busy & ~(NUM_REQ'(1) << gi)));
        end
    endgenerate

    assign tx_sel      = tx_sel_reg;
    assign grant_id    = grant_id_reg;
    assign grant_valid = (state_reg == GRANT) || (state_reg == BUSY);
    assign grant_count = grant_count_reg;

endmodule

// File: tb/tb_sonic_tx_arbiter.sv
// Testbench for sonic_tx_arbiter: directed scenarios followed by randomized
// traffic, all checked every cycle against a transaction-level owner model.
module tb_sonic_tx_arbiter;
    localparam int N = 4;
`ifdef SONIC_TX_ARB_WATCHDOG_EN
    localparam int WD = 16;
`else
    localparam int WD = 0;
`endif

    logic         clk_in = 1'b0;
    logic         reset = 1'b1;
    logic         init = 1'b0;
    logic         tx_ws = 1'b0;
    logic [N-1:0] req_ready = '0;
    logic [N-1:0] req_busy = '0;
    logic [N-1:0] tx_sel, tx_ready_others;
    logic [1:0]   grant_id;
    logic         grant_valid;
    logic [15:0]  grant_count;
    logic         wd_error;

    sonic_tx_arbiter #(.NUM_REQ(N), .ID_WIDTH(2), .WATCHDOG_CYCLES(16)) dut (
        .clk_in(clk_in), .reset(reset), .init(init),
        .req_ready(req_ready), .req_busy(req_busy), .tx_ws(tx_ws),
        .tx_sel(tx_sel), .tx_ready_others(tx_ready_others),
        .grant_id(grant_id), .grant_valid(grant_valid),
        .grant_count(grant_count), .wd_error(wd_error)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: who owns the backend, whether the owner is mid-TLP,
    // whether we are in the one-cycle cool-down after a release, and fairness pointer.
    int          m_owner = -1;
    bit          m_in_tlp = 0;
    bit          m_cool = 0;
    int          m_ptr = 0;
    int          m_last = 0;
    int          m_age = 0;
    int unsigned m_count = 0;
    bit          m_wderr = 0;
    bit          m_new_grant = 0;

    task automatic model_clear();
        m_owner = -1; m_in_tlp = 0; m_cool = 0; m_ptr = 0;
        m_last = 0; m_age = 0; m_count = 0; m_wderr = 0;
    endtask

    task automatic model_release();
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_cool  = 1;
    endtask

    task automatic model_edge();
        m_new_grant = 0;
        if (reset || init) begin
            model_clear();
        end else if (m_cool) begin
            m_cool = 0;
        end else if (m_owner < 0) begin
            if (req_ready != 0 && !tx_ws) begin
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && req_ready[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                end
                m_count = (m_count + 1) % 65536;
                m_last = m_owner; m_in_tlp = 0; m_age = 0; m_new_grant = 1;
            end
        end else if (m_in_tlp) begin
            if (!req_busy[m_owner]) begin
                if (req_ready[m_owner]) begin m_in_tlp = 0; m_age = 0; end
                else model_release();
            end
        end else begin
            if (req_busy[m_owner]) m_in_tlp = 1;
            else if (!req_ready[m_owner]) model_release();
            else begin
                m_age++;
                if (WD > 0 && m_age >= WD) begin model_release(); m_wderr = 1; end
            end
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] e_sel, e_oth;
        e_sel = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        for (int i = 0; i < N; i++)
            e_oth[i] = (m_owner != i) || ((req_busy & ~N'(1 << i)) != 0);
        check_val("tx_sel", tx_sel, e_sel);
        check_val("tx_ready_others", tx_ready_others, e_oth);
        check_val("grant_id", grant_id, m_last);
        check_val("grant_valid", grant_valid, m_owner >= 0);
        check_val("grant_count", grant_count, m_count);
        check_val("wd_error", wd_error, m_wderr);
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
        if (m_new_grant) $display("t=%0t grant #%0d -> client %0d", $time, m_count, m_owner);
        compare_all();
    endtask

    task automatic do_init();
        init = 1; req_ready = '0; req_busy = '0; tx_ws = 0;
        step();
        init = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w, zeros, held;
        // Reset state
        repeat (3) step();
        check_val("rst_others", tx_ready_others, 4'hF);
        @(negedge clk_in) reset = 0;
        step();

        // Single request
        req_ready = 4'b0100;
        step();
        check_val("single_sel", tx_sel, 4'b0100);
        check_val("single_id", grant_id, 2);
        check_val("single_cnt", grant_count, 1);
        check_val("single_oth", tx_ready_others, 4'b1011);
        req_ready = '0;
        step(); step();

        // Round-robin with 3-cycle busy pulses
        do_init();
        req_ready = 4'hF;
        for (int i = 0; i < 5; i++) begin
            w = 0;
            while (tx_sel == 0 && w < 10) begin step(); w++; end
            check_val("rr_order", grant_id, i % N);
            if (i < 4) begin
                req_busy = tx_sel;
                repeat (3) step();
                req_busy = '0;
                req_ready = 4'hF & ~tx_sel;
                step();
                zeros = 0;
                req_ready = 4'hF;
                while (tx_sel == 0 && zeros < 10) begin zeros++; step(); end
                check_val("rr_gap", zeros, 2);
            end
        end

        // Back-to-back TLPs by client 1
        do_init();
        req_ready = 4'b0010;
        step();
        check_val("b2b_sel0", tx_sel, 4'b0010);
        req_ready = 4'hF; req_busy = 4'b0010;
        step();
        req_busy = '0;
        step();
        check_val("b2b_sel1", tx_sel, 4'b0010);
        req_busy = 4'b0010;
        step(); step();
        check_val("b2b_sel2", tx_sel, 4'b0010);
        check_val("b2b_cnt", grant_count, 1);
        req_busy = '0; req_ready = 4'b1101;
        step();
        check_val("b2b_rel", tx_sel, 0);

        // Withdrawal by client 3, then tx_ws deferral
        do_init();
        req_ready = 4'b1000;
        step();
        check_val("wdr_id", grant_id, 3);
        req_ready = 4'hF;
        step();
        req_ready = 4'b0111;
        step();
        check_val("wdr_rel", tx_sel, 0);
        step();
        step();
        check_val("wdr_next", tx_sel, 4'b0001);
        req_ready = 4'b1110;
        step();
        tx_ws = 1; req_ready = 4'hF;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("ws_hold", tx_sel, 0);
        end
        tx_ws = 0;
        step();
        check_val("ws_grant", tx_sel, 4'b0010);

        // init mid-BUSY, plus a busy violation seen on tx_ready_others
        do_init();
        req_ready = 4'b0001;
        step();
        req_busy = 4'b0001;
        step();
        check_val("ib_valid", grant_valid, 1);
        req_busy = 4'b0011;
        #1;
        check_val("viol_others", tx_ready_others, 4'hF);
        req_busy = 4'b0001;
        init = 1;
        step();
        init = 0; req_busy = '0;
        check_val("ib_sel", tx_sel, 0);
        check_val("ib_cnt", grant_count, 0);
        check_val("ib_id", grant_id, 0);
        req_ready = 4'hF;
        step();
        check_val("ib_rearb", tx_sel, 4'b0001);

        // Grant held without busy
        do_init();
        req_ready = 4'b0100;
        step();
        check_val("wdog_id", grant_id, 2);
        held = 0;
        while (tx_sel == 4'b0100 && held < 130) begin held++; step(); end
`ifdef SONIC_TX_ARB_WATCHDOG_EN
        check_val("wdog_held", held, 16);
        check_val("wdog_err", wd_error, 1);
        repeat (10) step();
        check_val("wdog_sticky", wd_error, 1);
`else
        check_val("wdog_held", held, 130);
        check_val("wdog_err", wd_error, 0);
`endif

        // Randomized traffic with legal busy behaviour
        do_init();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(7) == 0) req_ready[i] = ~req_ready[i];
            if (m_owner >= 0) begin
                if ($urandom_range(3) == 0) req_busy[m_owner] = ~req_busy[m_owner];
                req_busy = req_busy & N'(1 << m_owner);
            end else begin
                req_busy = '0;
            end
            tx_ws = ($urandom_range(3) == 0);
            init = ($urandom_range(199) == 0);
            step();
        end
        init = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
